// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and the
// requester identifiers used for round-robin bookkeeping.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_BUSY = 2'd1,
      LDR_BUSY = 2'd2
   } arbState_e;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_LDR = 1'b1
   } portId_e;

   // Wide enough for any legal TIMEOUT (2..255).
   localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the unified memory port and the error
// outputs. The arbiter uses the master view, its environment the slave view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_done;
   logic [DATA_W-1:0] ldr_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              err_pulse;
   logic              err_flag;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  mem_rdata, mem_ready,
      output cpu_done, cpu_rdata, cpu_stall,
      output ldr_done, ldr_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output err_pulse, err_flag
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output mem_rdata, mem_ready,
      input  cpu_done, cpu_rdata, cpu_stall,
      input  ldr_done, ldr_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  err_pulse, err_flag
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / program loader) arbiter onto a single memory port with
// round-robin conflict resolution and a wait-cycle timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.master bus
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   arbState_e         state_r;
   arbState_e         nextState_s;
   portId_e           lastGrant_r;
   logic [WAIT_W-1:0] waitCnt_r;

   logic              cpuElig_s;
   logic              ldrElig_s;
   logic              grantCpu_s;
   logic              grantLdr_s;
   logic              finishOk_s;
   logic              finishErr_s;
   logic              ownerCpu_s;

   logic              cpuDone_r;
   logic              ldrDone_r;
   logic              errPulse_r;
   logic              errFlag_r;
   logic              memReq_r;
   logic              memWe_r;
   logic [ADDR_W-1:0] memAddr_r;
   logic [DATA_W-1:0] memWdata_r;
   logic [DATA_W-1:0] cpuRdata_r;
   logic [DATA_W-1:0] ldrRdata_r;

   // A requester still holding req during its done cycle must not be re-served.
   assign cpuElig_s  = bus.cpu_req & ~cpuDone_r;
   assign ldrElig_s  = bus.ldr_req & ~ldrDone_r;
   assign ownerCpu_s = (state_r == CPU_BUSY);

   // Grant selection, access completion and next-state decode.
   always_comb begin
      nextState_s = state_r;
      grantCpu_s  = 1'b0;
      grantLdr_s  = 1'b0;
      finishOk_s  = 1'b0;
      finishErr_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (cpuElig_s && ldrElig_s) begin
               if (lastGrant_r == PORT_LDR) begin
                  grantCpu_s = 1'b1;
               end else begin
                  grantLdr_s = 1'b1;
               end
            end else if (cpuElig_s) begin
               grantCpu_s = 1'b1;
            end else if (ldrElig_s) begin
               grantLdr_s = 1'b1;
            end else begin
               grantCpu_s = 1'b0;
            end
            if (grantCpu_s) begin
               nextState_s = CPU_BUSY;
            end else if (grantLdr_s) begin
               nextState_s = LDR_BUSY;
            end else begin
               nextState_s = IDLE;
            end
         end
         CPU_BUSY, LDR_BUSY: begin
            // mem_ready on the final wait cycle still counts as success.
            if (bus.mem_ready) begin
               finishOk_s  = 1'b1;
               nextState_s = IDLE;
            end else if (waitCnt_r == WAIT_LAST) begin
               finishErr_s = 1'b1;
               nextState_s = IDLE;
            end else begin
               nextState_s = state_r;
            end
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Memory-port registers, wait counter, done/error pulses and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrant_r <= PORT_LDR;
         waitCnt_r   <= {WAIT_W{1'b0}};
         cpuDone_r   <= 1'b0;
         ldrDone_r   <= 1'b0;
         errPulse_r  <= 1'b0;
         errFlag_r   <= 1'b0;
         memReq_r    <= 1'b0;
         memWe_r     <= 1'b0;
         memAddr_r   <= {ADDR_W{1'b0}};
         memWdata_r  <= {DATA_W{1'b0}};
         cpuRdata_r  <= {DATA_W{1'b0}};
         ldrRdata_r  <= {DATA_W{1'b0}};
      end else begin
         cpuDone_r  <= 1'b0;
         ldrDone_r  <= 1'b0;
         errPulse_r <= 1'b0;
         if (grantCpu_s) begin
            memReq_r    <= 1'b1;
            memWe_r     <= bus.cpu_we;
            memAddr_r   <= bus.cpu_addr;
            memWdata_r  <= bus.cpu_wdata;
            waitCnt_r   <= {WAIT_W{1'b0}};
            lastGrant_r <= PORT_CPU;
         end else if (grantLdr_s) begin
            memReq_r    <= 1'b1;
            memWe_r     <= bus.ldr_we;
            memAddr_r   <= bus.ldr_addr;
            memWdata_r  <= bus.ldr_wdata;
            waitCnt_r   <= {WAIT_W{1'b0}};
            lastGrant_r <= PORT_LDR;
         end else if (finishOk_s || finishErr_s) begin
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= {ADDR_W{1'b0}};
            memWdata_r <= {DATA_W{1'b0}};
            waitCnt_r  <= {WAIT_W{1'b0}};
            if (finishErr_s) begin
               errPulse_r <= 1'b1;
               errFlag_r  <= 1'b1;
            end
            if (ownerCpu_s) begin
               cpuDone_r <= 1'b1;
               if (finishErr_s) begin
                  cpuRdata_r <= {DATA_W{1'b0}};
               end else if (!memWe_r) begin
                  cpuRdata_r <= bus.mem_rdata;
               end
            end else begin
               ldrDone_r <= 1'b1;
               if (finishErr_s) begin
                  ldrRdata_r <= {DATA_W{1'b0}};
               end else if (!memWe_r) begin
                  ldrRdata_r <= bus.mem_rdata;
               end
            end
         end else if (state_r != IDLE) begin
            waitCnt_r <= waitCnt_r + 8'd1;
         end
      end
   end

   assign bus.cpu_done  = cpuDone_r;
   assign bus.ldr_done  = ldrDone_r;
   assign bus.cpu_rdata = cpuRdata_r;
   assign bus.ldr_rdata = ldrRdata_r;
   assign bus.cpu_stall = bus.cpu_req & ~cpuDone_r;
   assign bus.mem_req   = memReq_r;
   assign bus.mem_we    = memWe_r;
   assign bus.mem_addr  = memAddr_r;
   assign bus.mem_wdata = memWdata_r;
   assign bus.err_pulse = errPulse_r;
   assign bus.err_flag  = errFlag_r;

endmodule
